// File: rtl/ascon_aead_seq_if.sv
// Host/datapath bundle for the Ascon AEAD control sequencer.
// Latency: none, this is wiring only; slave = sequencer, master = host/datapath side.
// Backpressure: data_valid_i/data_ready_o form a valid-ready pair; a block moves when both are high.
// Optional: ASCON_TAG_CHECK_EN adds tag_eq_i (datapath tag compare) and auth_ok_o.
interface ascon_aead_seq_if #(
    parameter int CNT_W = 4
);
    logic             start_i;
    logic             dec_i;
    logic [CNT_W-1:0] nb_ad_i;
    logic [CNT_W-1:0] nb_msg_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic [3:0]       round_o;
    logic             perm_en_o;
    logic             load_init_o;
    logic             xor_data_o;
    logic             replace_rate_o;
    logic             xor_key_begin_o;
    logic             xor_key_end_o;
    logic             xor_domain_o;
    logic             en_reg_cipher_o;
    logic             en_reg_tag_o;
    logic             cipher_valid_o;
    logic             busy_o;
    logic             done_o;
    logic             tag_valid_o;
`ifdef ASCON_TAG_CHECK_EN
    logic             tag_eq_i;
    logic             auth_ok_o;

    modport slave (
        input  start_i, dec_i, nb_ad_i, nb_msg_i, data_valid_i, tag_eq_i,
        output data_ready_o, round_o, perm_en_o, load_init_o, xor_data_o,
               replace_rate_o, xor_key_begin_o, xor_key_end_o, xor_domain_o,
               en_reg_cipher_o, en_reg_tag_o, cipher_valid_o, busy_o, done_o,
               tag_valid_o, auth_ok_o
    );
    modport master (
        output start_i, dec_i, nb_ad_i, nb_msg_i, data_valid_i, tag_eq_i,
        input  data_ready_o, round_o, perm_en_o, load_init_o, xor_data_o,
               replace_rate_o, xor_key_begin_o, xor_key_end_o, xor_domain_o,
               en_reg_cipher_o, en_reg_tag_o, cipher_valid_o, busy_o, done_o,
               tag_valid_o, auth_ok_o
    );
`else
    modport slave (
        input  start_i, dec_i, nb_ad_i, nb_msg_i, data_valid_i,
        output data_ready_o, round_o, perm_en_o, load_init_o, xor_data_o,
               replace_rate_o, xor_key_begin_o, xor_key_end_o, xor_domain_o,
               en_reg_cipher_o, en_reg_tag_o, cipher_valid_o, busy_o, done_o,
               tag_valid_o
    );
    modport master (
        output start_i, dec_i, nb_ad_i, nb_msg_i, data_valid_i,
        input  data_ready_o, round_o, perm_en_o, load_init_o, xor_data_o,
               replace_rate_o, xor_key_begin_o, xor_key_end_o, xor_domain_o,
               en_reg_cipher_o, en_reg_tag_o, cipher_valid_o, busy_o, done_o,
               tag_valid_o
    );
`endif
endinterface

// File: rtl/ascon_aead_seq.sv
// Ascon AEAD control sequencer: per-op AD/message block counts, encrypt and decrypt.
// Latency: start to done_o = 1 + RA + nb_ad*RB + (nb_msg-1)*RB + RA + 1 cycles plus host wait cycles.
// Backpressure: *_WAIT states hold data_ready_o high and stall with no output change until data_valid_i.
// Ports: clock_i/reset_i (async active-high); bus (ascon_aead_seq_if.slave) carries start/config,
//   the data block handshake, datapath strobes/round index and the registered status outputs.
// Optional: ASCON_TAG_CHECK_EN enables tag_eq_i sampling in DONE and the auth_ok_o result.
module ascon_aead_seq #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    ascon_aead_seq_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_AD_WAIT, S_AD_PERM, S_MSG_WAIT, S_MSG_PERM, S_FINAL, S_DONE
    } state_t;

    // First round index of each permutation; both end at round 11.
    localparam logic [3:0] K_A0   = 4'(12 - ROUNDS_A);
    localparam logic [3:0] K_B0   = 4'(12 - ROUNDS_B);
    localparam logic [3:0] K_LAST = 4'd11;

    state_t           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] nb_ad_q, nb_ad_d;
    logic [CNT_W-1:0] nb_msg_q, nb_msg_d;
    logic             dec_q, dec_d;
    logic             cipher_valid_q, cipher_valid_d;
    logic             done_q, done_d;
    logic             tag_valid_q, tag_valid_d;
`ifdef ASCON_TAG_CHECK_EN
    logic             auth_ok_q, auth_ok_d;
`endif

    logic       in_wait;
    logic       accept;
    logic       last_ad;
    logic       last_msg;
    logic [3:0] cur_k;
    logic       last_round;
    logic       start_acc;

    // Shared decode. In a WAIT state the accept cycle is itself round 1 of the
    // next permutation, so the displayed round is that permutation's first index.
    always_comb begin
        in_wait   = (state_q == S_AD_WAIT) || (state_q == S_MSG_WAIT);
        accept    = in_wait && bus.data_valid_i;
        last_ad   = (ad_cnt_q == nb_ad_q - CNT_W'(1));
        last_msg  = (msg_cnt_q == nb_msg_q - CNT_W'(1));
        start_acc = (state_q == S_IDLE) && bus.start_i;
        case (state_q)
            S_AD_WAIT:  cur_k = K_B0;
            S_MSG_WAIT: cur_k = last_msg ? K_A0 : K_B0;
            default:    cur_k = rnd_q;
        endcase
        last_round = (cur_k == K_LAST);
    end

    // State and counter registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            rnd_q          <= '0;
            ad_cnt_q       <= '0;
            msg_cnt_q      <= '0;
            nb_ad_q        <= '0;
            nb_msg_q       <= '0;
            dec_q          <= 1'b0;
            cipher_valid_q <= 1'b0;
            done_q         <= 1'b0;
            tag_valid_q    <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
            auth_ok_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            rnd_q          <= rnd_d;
            ad_cnt_q       <= ad_cnt_d;
            msg_cnt_q      <= msg_cnt_d;
            nb_ad_q        <= nb_ad_d;
            nb_msg_q       <= nb_msg_d;
            dec_q          <= dec_d;
            cipher_valid_q <= cipher_valid_d;
            done_q         <= done_d;
            tag_valid_q    <= tag_valid_d;
`ifdef ASCON_TAG_CHECK_EN
            auth_ok_q      <= auth_ok_d;
`endif
        end
    end

    // Next state and counters.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        ad_cnt_d  = ad_cnt_q;
        msg_cnt_d = msg_cnt_q;
        nb_ad_d   = nb_ad_q;
        nb_msg_d  = nb_msg_q;
        dec_d     = dec_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d   = S_INIT;
                    rnd_d     = K_A0;
                    ad_cnt_d  = '0;
                    msg_cnt_d = '0;
                    dec_d     = bus.dec_i;
                    nb_ad_d   = bus.nb_ad_i;
                    // A zero message count still runs one (final) block.
                    nb_msg_d  = (bus.nb_msg_i == '0) ? CNT_W'(1) : bus.nb_msg_i;
                end
            end
            S_INIT: begin
                if (last_round) state_d = (nb_ad_q != '0) ? S_AD_WAIT : S_MSG_WAIT;
                else            rnd_d   = rnd_q + 4'd1;
            end
            S_AD_WAIT: begin
                if (accept) begin
                    if (last_round) begin
                        // Single-round p^b: block completes on the accept cycle.
                        ad_cnt_d = ad_cnt_q + CNT_W'(1);
                        state_d  = last_ad ? S_MSG_WAIT : S_AD_WAIT;
                    end else begin
                        rnd_d   = cur_k + 4'd1;
                        state_d = S_AD_PERM;
                    end
                end
            end
            S_AD_PERM: begin
                if (last_round) begin
                    ad_cnt_d = ad_cnt_q + CNT_W'(1);
                    state_d  = last_ad ? S_MSG_WAIT : S_AD_WAIT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_MSG_WAIT: begin
                if (accept) begin
                    if (last_msg) begin
                        if (last_round) state_d = S_DONE;
                        else begin
                            rnd_d   = cur_k + 4'd1;
                            state_d = S_FINAL;
                        end
                    end else if (last_round) begin
                        msg_cnt_d = msg_cnt_q + CNT_W'(1);
                    end else begin
                        rnd_d   = cur_k + 4'd1;
                        state_d = S_MSG_PERM;
                    end
                end
            end
            S_MSG_PERM: begin
                if (last_round) begin
                    msg_cnt_d = msg_cnt_q + CNT_W'(1);
                    state_d   = S_MSG_WAIT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_FINAL: begin
                if (last_round) state_d = S_DONE;
                else            rnd_d   = rnd_q + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes (combinational) and next values of the registered status outputs.
    always_comb begin
        logic perm_state;
        logic fin_end;
        logic ad_end;
        perm_state = (state_q == S_INIT) || (state_q == S_AD_PERM) ||
                     (state_q == S_MSG_PERM) || (state_q == S_FINAL);
        fin_end    = last_round && ((state_q == S_FINAL) ||
                     ((state_q == S_MSG_WAIT) && accept && last_msg));
        ad_end     = last_round && last_ad &&
                     ((state_q == S_AD_PERM) || ((state_q == S_AD_WAIT) && accept));

        bus.data_ready_o    = in_wait;
        bus.round_o         = (state_q == S_IDLE || state_q == S_DONE) ? 4'd0 : cur_k;
        bus.perm_en_o       = perm_state || accept;
        bus.load_init_o     = (state_q == S_INIT) && (rnd_q == K_A0);
        bus.xor_data_o      = accept;
        bus.replace_rate_o  = accept && (state_q == S_MSG_WAIT) && dec_q;
        bus.xor_key_begin_o = accept && (state_q == S_MSG_WAIT) && last_msg;
        bus.xor_key_end_o   = ((state_q == S_INIT) && last_round) || fin_end;
        bus.xor_domain_o    = ((state_q == S_INIT) && last_round && (nb_ad_q == '0)) || ad_end;
        bus.en_reg_cipher_o = accept && (state_q == S_MSG_WAIT);
        bus.en_reg_tag_o    = fin_end;
        bus.busy_o          = (state_q != S_IDLE);

        cipher_valid_d = accept && (state_q == S_MSG_WAIT);
        done_d         = (state_q == S_DONE);
        if (state_q == S_DONE) tag_valid_d = 1'b1;
        else if (start_acc)    tag_valid_d = 1'b0;
        else                   tag_valid_d = tag_valid_q;
`ifdef ASCON_TAG_CHECK_EN
        // Encrypt never authenticates, so dec_q gates the comparator.
        if (state_q == S_DONE) auth_ok_d = dec_q && bus.tag_eq_i;
        else if (start_acc)    auth_ok_d = 1'b0;
        else                   auth_ok_d = auth_ok_q;
`endif
    end

    assign bus.cipher_valid_o = cipher_valid_q;
    assign bus.done_o         = done_q;
    assign bus.tag_valid_o    = tag_valid_q;
`ifdef ASCON_TAG_CHECK_EN
    assign bus.auth_ok_o      = auth_ok_q;
`endif

endmodule
